// File: rtl/ret_addr_stack_pkg.sv
// Shared CPU constants for PC-width logic and the return-address stack operation encoding.
package ret_addr_stack_pkg;

  localparam int unsigned ADDR_W    = 32;
  localparam int unsigned RAS_DEPTH = 8;

  // One decoded action per clock; the priority order is resolved before encoding.
  typedef enum logic [2:0] {
    OpHold,
    OpClear,
    OpPush,
    OpPop,
    OpReplace,
    OpWrap,
    OpDrop
  } ras_op_e;

endpackage

// File: rtl/ras_mem.sv
// DEPTH x AW register file for the return-address stack: one synchronous write port and
// one asynchronous read port, no reset.
module ras_mem #(
  parameter int unsigned DEPTH = 8,
  parameter int unsigned AW    = 32
) (
  input  logic                     clk_i,
  input  logic                     we_i,
  input  logic [$clog2(DEPTH)-1:0] waddr_i,
  input  logic [AW-1:0]            wdata_i,
  input  logic [$clog2(DEPTH)-1:0] raddr_i,
  output logic [AW-1:0]            rdata_o
);

  logic [AW-1:0] mem_q [DEPTH];

  always_ff @(posedge clk_i) begin
    if (we_i) begin
      mem_q[waddr_i] <= wdata_i;
    end
  end

  assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/ret_addr_stack.sv
// Return-address stack feeding a predicted return target to the next-PC mux.
// Define RAS_OVERFLOW_WRAP_EN to overwrite the oldest entry on overflow instead of dropping.
module ret_addr_stack
  import ret_addr_stack_pkg::*;
#(
  parameter int unsigned DEPTH = RAS_DEPTH,
  parameter int unsigned AW    = ADDR_W
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   flush,
  input  logic                   push,
  input  logic [AW-1:0]          push_addr,
  input  logic                   pop,
  output logic [AW-1:0]          top_addr,
  output logic                   top_valid,
  output logic [$clog2(DEPTH):0] count,
  output logic                   full
`ifndef RAS_OVERFLOW_WRAP_EN
  ,
  output logic                   overflow_err
`endif
);

  localparam int unsigned SpW  = $clog2(DEPTH);
  localparam int unsigned CntW = SpW + 1;
  localparam logic [CntW-1:0] CntFull = CntW'(DEPTH);

  logic [SpW-1:0]  sp_q, sp_d, sp_top;
  logic [CntW-1:0] count_q, count_d;
  logic            empty, is_full;
  logic            mem_we;
  logic [SpW-1:0]  mem_waddr;
  logic [AW-1:0]   mem_rdata;
  ras_op_e         op;
`ifndef RAS_OVERFLOW_WRAP_EN
  logic            err_q, err_d;
`endif

  assign empty   = (count_q == '0);
  assign is_full = (count_q == CntFull);
  assign sp_top  = sp_q - SpW'(1);

  always_comb begin
    op = OpHold;
    if (reset || flush) begin
      op = OpClear;
    end else if (push && pop && !empty) begin
      op = OpReplace;
    end else if (push && is_full) begin
`ifdef RAS_OVERFLOW_WRAP_EN
      op = OpWrap;
`else
      op = OpDrop;
`endif
    end else if (push) begin
      op = OpPush;
    end else if (pop && !empty) begin
      op = OpPop;
    end
  end

  always_comb begin
    sp_d      = sp_q;
    count_d   = count_q;
    mem_we    = 1'b0;
    mem_waddr = sp_q;
`ifndef RAS_OVERFLOW_WRAP_EN
    err_d     = err_q;
`endif
    unique case (op)
      OpClear: begin
        sp_d    = '0;
        count_d = '0;
`ifndef RAS_OVERFLOW_WRAP_EN
        err_d   = 1'b0;
`endif
      end
      OpPush: begin
        mem_we  = 1'b1;
        sp_d    = sp_q + SpW'(1);
        count_d = count_q + CntW'(1);
      end
      // Circular overwrite: the slot at sp is the oldest entry once full.
      OpWrap: begin
        mem_we = 1'b1;
        sp_d   = sp_q + SpW'(1);
      end
      OpPop: begin
        sp_d    = sp_top;
        count_d = count_q - CntW'(1);
      end
      OpReplace: begin
        mem_we    = 1'b1;
        mem_waddr = sp_top;
      end
      OpDrop: begin
`ifndef RAS_OVERFLOW_WRAP_EN
        err_d = 1'b1;
`endif
      end
      default: begin
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      sp_q    <= '0;
      count_q <= '0;
`ifndef RAS_OVERFLOW_WRAP_EN
      err_q   <= 1'b0;
`endif
    end else begin
      sp_q    <= sp_d;
      count_q <= count_d;
`ifndef RAS_OVERFLOW_WRAP_EN
      err_q   <= err_d;
`endif
    end
  end

  ras_mem #(
    .DEPTH(DEPTH),
    .AW   (AW)
  ) u_mem (
    .clk_i  (clk),
    .we_i   (mem_we),
    .waddr_i(mem_waddr),
    .wdata_i(push_addr),
    .raddr_i(sp_top),
    .rdata_o(mem_rdata)
  );

  // Forced to zero when empty so stale or uninitialised storage never leaks out.
  assign top_addr  = empty ? '0 : mem_rdata;
  assign top_valid = !empty;
  assign count     = count_q;
  assign full      = is_full;
`ifndef RAS_OVERFLOW_WRAP_EN
  assign overflow_err = err_q;
`endif

endmodule

// File: tb/tb_ret_addr_stack.sv
// Bench for ret_addr_stack: queue-based reference model compared every cycle, plus
// hand-computed checkpoints; honours RAS_OVERFLOW_WRAP_EN.
module tb_ret_addr_stack;

  localparam int unsigned Depth = 8;

  logic        clk = 1'b0;
  logic        reset, flush, push, pop;
  logic [31:0] push_addr;
  logic [31:0] top_addr;
  logic        top_valid, full;
  logic [3:0]  count;
  logic        overflow_err;

  int n_cmp = 0;
  int n_bad = 0;
  bit chk_en = 1'b0;

  logic [31:0] mq[$];
  bit          merr = 1'b0;

  always #5 clk = ~clk;

  ret_addr_stack #(
    .DEPTH(Depth),
    .AW   (32)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .flush    (flush),
    .push     (push),
    .push_addr(push_addr),
    .pop      (pop),
    .top_addr (top_addr),
    .top_valid(top_valid),
    .count    (count),
    .full     (full)
`ifndef RAS_OVERFLOW_WRAP_EN
    ,
    .overflow_err(overflow_err)
`endif
  );

`ifdef RAS_OVERFLOW_WRAP_EN
  assign overflow_err = 1'b0;
`endif

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: the stack as a queue, newest entry at the back.
  always @(posedge clk) begin
    if (reset || flush) begin
      mq.delete();
      merr = 1'b0;
    end else if (push && pop && mq.size() != 0) begin
      mq[mq.size()-1] = push_addr;
    end else if (push) begin
      if (mq.size() == Depth) begin
`ifdef RAS_OVERFLOW_WRAP_EN
        void'(mq.pop_front());
        mq.push_back(push_addr);
`else
        merr = 1'b1;
`endif
      end else begin
        mq.push_back(push_addr);
      end
    end else if (pop && mq.size() != 0) begin
      void'(mq.pop_back());
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      check("model_top_addr", top_addr, (mq.size() != 0) ? mq[mq.size()-1] : 32'h0);
      check("model_top_valid", {31'h0, top_valid}, {31'h0, mq.size() != 0});
      check("model_count", {28'h0, count}, mq.size());
      check("model_full", {31'h0, full}, {31'h0, mq.size() == Depth});
`ifndef RAS_OVERFLOW_WRAP_EN
      check("model_overflow_err", {31'h0, overflow_err}, {31'h0, merr});
`endif
    end
  end

  task automatic cyc(input logic ps, input logic pp, input logic [31:0] a,
                     input logic fl, input logic rs);
    @(negedge clk);
    push      = ps;
    pop       = pp;
    push_addr = a;
    flush     = fl;
    reset     = rs;
    @(posedge clk);
    #1;
  endtask

  task automatic check_reset_state(input string tag);
    check({tag, "_top_addr"}, top_addr, 32'h0);
    check({tag, "_top_valid"}, {31'h0, top_valid}, 32'h0);
    check({tag, "_count"}, {28'h0, count}, 32'h0);
    check({tag, "_full"}, {31'h0, full}, 32'h0);
    check({tag, "_overflow_err"}, {31'h0, overflow_err}, 32'h0);
  endtask

  initial begin
    reset = 1'b1; flush = 1'b0; push = 1'b0; pop = 1'b0; push_addr = '0;
    cyc(0, 0, 0, 0, 1);
    chk_en = 1'b1;
    cyc(0, 0, 0, 0, 1);
    check_reset_state("reset");

    // Basic push/pop ordering
    cyc(1, 0, 32'h0040_0004, 0, 0);
    cyc(1, 0, 32'h0040_0010, 0, 0);
    cyc(1, 0, 32'h0040_002C, 0, 0);
    check("push3_count", {28'h0, count}, 32'd3);
    check("push3_top", top_addr, 32'h0040_002C);
    cyc(0, 1, 0, 0, 0);
    check("pop1_top", top_addr, 32'h0040_0010);
    cyc(0, 1, 0, 0, 0);
    check("pop2_top", top_addr, 32'h0040_0004);
    cyc(0, 1, 0, 0, 0);
    check("pop3_valid", {31'h0, top_valid}, 32'h0);
    check("pop3_top", top_addr, 32'h0);

    // Underflow is harmless
    cyc(0, 1, 0, 0, 0);
    cyc(0, 1, 0, 0, 0);
    check("underflow_count", {28'h0, count}, 32'd0);
    check("underflow_no_x", {31'h0, ^{top_addr, top_valid, count, full} === 1'bx}, 32'h0);
    cyc(1, 0, 32'h0040_0100, 0, 0);
    check("after_underflow_top", top_addr, 32'h0040_0100);
    cyc(0, 1, 0, 0, 0);

    // Simultaneous push and pop replaces the top
    cyc(1, 0, 32'h0040_0010, 0, 0);
    cyc(1, 0, 32'h0040_0020, 0, 0);
    cyc(1, 1, 32'h0040_0040, 0, 0);
    check("replace_count", {28'h0, count}, 32'd2);
    check("replace_top", top_addr, 32'h0040_0040);
    cyc(0, 1, 0, 0, 0);
    check("replace_pop_top", top_addr, 32'h0040_0010);
    cyc(0, 1, 0, 0, 0);

    // Overflow
    for (int k = 0; k <= Depth; k++) cyc(1, 0, 32'h1000 + 32'(4 * k), 0, 0);
    check("ovf_full", {31'h0, full}, 32'h1);
`ifdef RAS_OVERFLOW_WRAP_EN
    check("ovf_top", top_addr, 32'h1020);
    for (int i = 0; i < Depth; i++) begin
      check("ovf_pop_seq", top_addr, 32'h1020 - 32'(4 * i));
      cyc(0, 1, 0, 0, 0);
    end
`else
    check("ovf_err", {31'h0, overflow_err}, 32'h1);
    check("ovf_top", top_addr, 32'h101C);
    cyc(1, 1, 32'h1050, 0, 0);
    check("ovf_replace_top", top_addr, 32'h1050);
    cyc(1, 1, 32'h101C, 0, 0);
    for (int i = 0; i < Depth; i++) begin
      check("ovf_pop_seq", top_addr, 32'h101C - 32'(4 * i));
      cyc(0, 1, 0, 0, 0);
    end
`endif
    check("ovf_drained_valid", {31'h0, top_valid}, 32'h0);

    // Flush wins over push
    for (int k = 0; k < 5; k++) cyc(1, 0, 32'h2000 + 32'(4 * k), 0, 0);
    check("preflush_count", {28'h0, count}, 32'd5);
    cyc(1, 0, 32'h2FFC, 1, 0);
    check_reset_state("flush");

    // Reset wins over push and pop; discarded push never appears
    cyc(1, 0, 32'h3000, 0, 0);
    cyc(1, 0, 32'h3004, 0, 0);
    cyc(1, 1, 32'h3333, 0, 1);
    check_reset_state("midreset");
    cyc(0, 1, 0, 0, 0);
    check("postreset_pop_top", top_addr, 32'h0);
    cyc(1, 0, 32'h4444, 0, 0);
    check("postreset_push_top", top_addr, 32'h4444);
    check("postreset_push_count", {28'h0, count}, 32'd1);
    cyc(0, 0, 0, 0, 0);

    @(negedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
